// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencer. Owns the 1/100 s timebase, the
//               IDLE/RUN/LAP/PAUSE state machine and the cascaded BCD time
//               digits (SS.cc, 00.00 - 59.99). Presents live or lap-frozen
//               time on a 16-bit BCD display bus.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DIV   = 500000,   // clock cycles per 1/100 s tick, >= 2
    parameter int PRE_W = 19        // prescaler width, 2**PRE_W >= DIV
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic        i_start_stop,
    input  logic        i_lap,
    input  logic        i_clear,
    output logic [15:0] o_disp,
    output logic        o_running,
    output logic        o_lap_active,
    output logic        o_tick,
    output logic        o_wrap
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_LAP   = 2'd2;
    localparam logic [1:0] c_PAUSE = 2'd3;

    // Terminal prescaler count; the tick fires on the cycle that holds it.
    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(DIV - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_hund;       // hundredths, 0-9
    logic [3:0]       r_tenth;      // tenths, 0-9
    logic [3:0]       r_sec_u;      // seconds units, 0-9
    logic [3:0]       r_sec_t;      // seconds tens, 0-5
    logic [15:0]      r_lap;
    logic             r_tick;
    logic             r_wrap;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic        w_active;
    logic        w_tick;
    logic        w_go_idle;
    logic        w_lap_load;
    logic        w_cy_hund;
    logic        w_cy_tenth;
    logic        w_cy_sec_u;
    logic        w_rollover;
    logic [3:0]  w_hund_inc;
    logic [3:0]  w_tenth_inc;
    logic [3:0]  w_sec_u_inc;
    logic [3:0]  w_sec_t_inc;
    logic [15:0] w_live;

    assign w_live   = {r_sec_t, r_sec_u, r_tenth, r_hund};
    assign w_active = (r_state == c_RUN) || (r_state == c_LAP);
    assign w_tick   = w_active && (r_pre == c_PRE_MAX);

    // Next-state decode; clear outranks start/stop, which outranks lap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start_stop) w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (i_clear)           w_state_nxt = c_IDLE;
                else if (i_start_stop) w_state_nxt = c_PAUSE;
                else if (i_lap)        w_state_nxt = c_LAP;
            end
            c_LAP: begin
                if (i_clear)           w_state_nxt = c_IDLE;
                else if (i_start_stop) w_state_nxt = c_PAUSE;
                else if (i_lap)        w_state_nxt = c_RUN;
            end
            c_PAUSE: begin
                if (i_clear)           w_state_nxt = c_IDLE;
                else if (i_start_stop) w_state_nxt = c_RUN;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Transition-qualified strobes: clearing on entry to IDLE, lap capture on RUN->LAP.
    always_comb begin
        w_go_idle  = (r_state != c_IDLE) && (w_state_nxt == c_IDLE);
        w_lap_load = (r_state == c_RUN)  && (w_state_nxt == c_LAP);
    end

    // Ripple-carry increment of the BCD digit chain; any out-of-range digit
    // is treated as its terminal value so the chain self-recovers to BCD.
    always_comb begin
        w_cy_hund  = (r_hund  >= 4'd9);
        w_cy_tenth = w_cy_hund  && (r_tenth >= 4'd9);
        w_cy_sec_u = w_cy_tenth && (r_sec_u >= 4'd9);
        w_rollover = w_cy_sec_u && (r_sec_t >= 4'd5);

        w_hund_inc  = w_cy_hund ? 4'd0 : r_hund + 4'd1;

        w_tenth_inc = r_tenth;
        if (w_cy_hund) begin
            w_tenth_inc = (r_tenth >= 4'd9) ? 4'd0 : r_tenth + 4'd1;
        end

        w_sec_u_inc = r_sec_u;
        if (w_cy_tenth) begin
            w_sec_u_inc = (r_sec_u >= 4'd9) ? 4'd0 : r_sec_u + 4'd1;
        end

        w_sec_t_inc = r_sec_t;
        if (w_cy_sec_u) begin
            w_sec_t_inc = (r_sec_t >= 4'd5) ? 4'd0 : r_sec_t + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prescaler: counts only while running, holds in PAUSE to keep the fraction.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_go_idle) begin
            r_pre <= '0;
        end else if (w_active) begin
            if (r_pre == c_PRE_MAX) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // Live time digits: advance on each tick, zero when returning to IDLE.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_hund  <= 4'd0;
            r_tenth <= 4'd0;
            r_sec_u <= 4'd0;
            r_sec_t <= 4'd0;
        end else if (w_go_idle) begin
            r_hund  <= 4'd0;
            r_tenth <= 4'd0;
            r_sec_u <= 4'd0;
            r_sec_t <= 4'd0;
        end else if (w_tick) begin
            r_hund  <= w_hund_inc;
            r_tenth <= w_tenth_inc;
            r_sec_u <= w_sec_u_inc;
            r_sec_t <= w_sec_t_inc;
        end
    end

    // Lap register: captures the pre-increment live digits when entering LAP.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_lap <= 16'h0000;
        end else if (w_go_idle) begin
            r_lap <= 16'h0000;
        end else if (w_lap_load) begin
            r_lap <= w_live;
        end
    end

    // Tick and rollover strobes, one cycle behind the increment; a clear
    // on the tick edge suppresses them since the count is discarded.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_tick && !w_go_idle;
            r_wrap <= w_tick && w_rollover && !w_go_idle;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_disp       = (r_state == c_LAP) ? r_lap : w_live;
    assign o_running    = w_active;
    assign o_lap_active = (r_state == c_LAP);
    assign o_tick       = r_tick;
    assign o_wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Scoreboard bench for stopwatch_ctrl. Stimulus pushes the
//               expected display/wrap value of every upcoming tick; a forked
//               monitor pops and compares on each o_tick pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s4, l4, c4, s2, l2, c2;
    logic [15:0] d4, d2;
    logic        run4, lapa4, tick4, wrap4;
    logic        run2, lapa2, tick2, wrap2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last4   = 0;
    int last2   = 0;

    typedef struct {
        logic [15:0] disp;
        logic        wrap;
        int          gap;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];

    stopwatch_ctrl #(.DIV(4), .PRE_W(3)) u_dut4 (
        .i_clk        (clk),
        .rst          (rst),
        .i_start_stop (s4),
        .i_lap        (l4),
        .i_clear      (c4),
        .o_disp       (d4),
        .o_running    (run4),
        .o_lap_active (lapa4),
        .o_tick       (tick4),
        .o_wrap       (wrap4)
    );

    stopwatch_ctrl #(.DIV(2), .PRE_W(2)) u_dut2 (
        .i_clk        (clk),
        .rst          (rst),
        .i_start_stop (s2),
        .i_lap        (l2),
        .i_clear      (c2),
        .o_disp       (d2),
        .o_running    (run2),
        .o_lap_active (lapa2),
        .o_tick       (tick2),
        .o_wrap       (wrap2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Centisecond count -> SS.cc BCD, by arithmetic rather than digit carries.
    function automatic logic [15:0] bcd(input int n);
        int m;
        m = n % 6000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_one(input int dut, input logic [15:0] disp, input logic wrap, input int gap);
        exp_t e;
        e.disp = disp;
        e.wrap = wrap;
        e.gap  = gap;
        if (dut == 4) q4.push_back(e);
        else          q2.push_back(e);
    endtask

    // Expected ticks for live counts from..to; the first has no spacing check.
    task automatic push(input int dut, input int from, input int to, input int gap);
        for (int n = from; n <= to; n++) begin
            push_one(dut, bcd(n), (n % 6000) == 0, (n == from) ? 0 : gap);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one command cycle from a negedge; sampled by the next posedge.
    task automatic pulse(input int dut, input logic s, input logic l, input logic c);
        if (dut == 4) begin s4 = s; l4 = l; c4 = c; end
        else          begin s2 = s; l2 = l; c2 = c; end
        @(negedge clk);
        s4 = 1'b0; l4 = 1'b0; c4 = 1'b0;
        s2 = 1'b0; l2 = 1'b0; c2 = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tick4) begin
                    if (q4.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut4_unexpected_tick: got tick with disp 0x%0h, expected no tick", d4);
                    end else begin
                        e = q4.pop_front();
                        chk("dut4_tick_disp", 32'(d4), 32'(e.disp));
                        chk("dut4_tick_wrap", 32'(wrap4), 32'(e.wrap));
                        if (e.gap != 0) chk("dut4_tick_gap", cyc - last4, e.gap);
                    end
                    last4 = cyc;
                end else if (wrap4) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut4_wrap_no_tick: got wrap=1 tick=0, expected wrap only with tick");
                end
                if (tick2) begin
                    if (q2.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut2_unexpected_tick: got tick with disp 0x%0h, expected no tick", d2);
                    end else begin
                        e = q2.pop_front();
                        chk("dut2_tick_disp", 32'(d2), 32'(e.disp));
                        chk("dut2_tick_wrap", 32'(wrap2), 32'(e.wrap));
                        if (e.gap != 0) chk("dut2_tick_gap", cyc - last2, e.gap);
                    end
                    last2 = cyc;
                end else if (wrap2) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut2_wrap_no_tick: got wrap=1 tick=0, expected wrap only with tick");
                end
            end
        end
    endtask

    initial begin
        int changed;
        rst = 1'b1;
        s4 = 1'b0; l4 = 1'b0; c4 = 1'b0;
        s2 = 1'b0; l2 = 1'b0; c2 = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        step(3);
        chk("rst_disp", 32'(d4), 32'h0);
        chk("rst_running", 32'(run4), 32'h0);
        chk("rst_lap_active", 32'(lapa4), 32'h0);
        chk("rst_tick", 32'(tick4), 32'h0);
        chk("rst_wrap", 32'(wrap4), 32'h0);
        rst = 1'b0;
        step(2);
        chk("idle_disp", 32'(d4), 32'h0);

        // 1: 40 running cycles -> 10 ticks, 4 cycles apart
        push(4, 1, 10, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(40);
        chk("t1_disp", 32'(d4), 32'h0010);
        chk("t1_running", 32'(run4), 32'h1);
        pulse(4, 1'b0, 1'b0, 1'b1);
        chk("t1_clear_disp", 32'(d4), 32'h0);
        chk("t1_ticks_done", q4.size(), 0);

        // 2: pause preserves the fractional tick
        push(4, 1, 5, 4);
        push(4, 6, 10, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(21);
        pulse(4, 1'b1, 1'b0, 1'b0);
        chk("t2_pause_disp", 32'(d4), 32'h0005);
        chk("t2_pause_running", 32'(run4), 32'h0);
        changed = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (d4 !== 16'h0005) changed++;
        end
        chk("t2_pause_changes", changed, 0);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(18);
        chk("t2_resume_disp", 32'(d4), 32'h0010);
        pulse(4, 1'b0, 1'b0, 1'b1);
        chk("t2_ticks_done", q4.size(), 0);

        // 3: lap freezes display at 00.03 while counting continues
        push(4, 1, 3, 4);
        for (int i = 0; i < 5; i++) push_one(4, 16'h0003, 1'b0, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(12);
        pulse(4, 1'b0, 1'b1, 1'b0);
        step(20);
        chk("t3_lap_disp", 32'(d4), 32'h0003);
        chk("t3_lap_active", 32'(lapa4), 32'h1);
        chk("t3_lap_running", 32'(run4), 32'h1);
        pulse(4, 1'b0, 1'b1, 1'b0);
        chk("t3_live_disp", 32'(d4), 32'h0008);
        chk("t3_live_lap_active", 32'(lapa4), 32'h0);
        pulse(4, 1'b0, 1'b0, 1'b1);
        chk("t3_ticks_done", q4.size(), 0);

        // 4: rollover 59.99 -> 00.00 on the DIV=2 instance
        push(2, 1, 6002, 2);
        pulse(2, 1'b1, 1'b0, 1'b0);
        step(11998);
        chk("t4_at_5999", 32'(d2), 32'h5999);
        chk("t4_no_wrap_yet", 32'(wrap2), 32'h0);
        chk("t4_running", 32'(run2), 32'h1);
        step(2);
        chk("t4_wrap_disp", 32'(d2), 32'h0000);
        chk("t4_wrap_pulse", 32'(wrap2), 32'h1);
        chk("t4_wrap_tick", 32'(tick2), 32'h1);
        step(1);
        chk("t4_wrap_one_cycle", 32'(wrap2), 32'h0);
        step(3);
        chk("t4_continues", 32'(d2), 32'h0002);
        pulse(2, 1'b0, 1'b0, 1'b1);
        chk("t4_lap_active", 32'(lapa2), 32'h0);
        chk("t4_ticks_done", q2.size(), 0);

        // 5: clear beats start/stop; lap ignored in IDLE
        push(4, 1, 125, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(500);
        chk("t5_disp_0125", 32'(d4), 32'h0125);
        pulse(4, 1'b1, 1'b0, 1'b1);
        chk("t5_clear_disp", 32'(d4), 32'h0);
        chk("t5_clear_running", 32'(run4), 32'h0);
        pulse(4, 1'b0, 1'b1, 1'b0);
        chk("t5_idle_lap_disp", 32'(d4), 32'h0);
        chk("t5_idle_lap_running", 32'(run4), 32'h0);
        chk("t5_idle_lap_active", 32'(lapa4), 32'h0);
        step(10);
        chk("t5_ticks_done", q4.size(), 0);

        // 6: asynchronous reset mid-cycle during LAP
        push(4, 1, 2, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(8);
        pulse(4, 1'b0, 1'b1, 1'b0);
        step(1);
        chk("t6_in_lap", 32'(lapa4), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_disp", 32'(d4), 32'h0);
        chk("t6_async_running", 32'(run4), 32'h0);
        chk("t6_async_lap_active", 32'(lapa4), 32'h0);
        chk("t6_async_tick", 32'(tick4), 32'h0);
        chk("t6_async_wrap", 32'(wrap4), 32'h0);
        chk("t6_ticks_done", q4.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        push(4, 1, 3, 4);
        pulse(4, 1'b1, 1'b0, 1'b0);
        step(12);
        chk("t6_restart_disp", 32'(d4), 32'h0003);
        pulse(4, 1'b0, 1'b0, 1'b1);
        step(5);
        chk("t6_restart_ticks_done", q4.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch sequencer that owns the 1/100 s timebase, the run/pause/lap/clear state machine and the cascaded BCD time digits (SS.cc, 00.00–59.99). It sits between the debounced button pulses and the 7-segment display multiplexer. It enables and advances the digit chain only while running. It presents either live or lap-frozen time on a 16-bit BCD display bus.

Parameters:
DIV, 500000, clock cycles per 1/100 s tick (50 MHz clock); must be >= 2; benches override it with small values.
PRE_W, 19, prescaler width; must satisfy 2^PRE_W >= DIV.

Ports:
i_clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
i_start_stop  input  1  single-cycle pulse, already synchronised and debounced upstream; toggles run/pause.
i_lap  input  1  single-cycle pulse; freezes or unfreezes the display while running.
i_clear  input  1  single-cycle pulse; returns the block to zero and IDLE.
o_disp  output  16  BCD {sec_tens, sec_units, tenths, hundredths}, 4 bits each.
o_running  output  1  high in RUN and LAP.
o_lap_active  output  1  high in LAP.
o_tick  output  1  one-cycle pulse on each 1/100 s increment.
o_wrap  output  1  one-cycle pulse on the 59.99 -> 00.00 rollover.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; prescaler 0; all digits 0; lap register 0; all outputs 0 (o_disp = 16'h0000).
- States: IDLE, RUN, LAP, PAUSE.
- Command priority when pulses coincide: i_clear > i_start_stop > i_lap.
- IDLE: i_start_stop -> RUN. i_lap and i_clear are ignored; counts are already zero.
- RUN: i_clear -> IDLE. i_start_stop -> PAUSE. i_lap -> LAP; on the same edge the lap register loads the current live digits.
- LAP: i_clear -> IDLE. i_start_stop -> PAUSE. i_lap -> RUN, display returns to live.
- PAUSE: i_clear -> IDLE. i_start_stop -> RUN. i_lap is ignored.
- Entering IDLE: prescaler, digits and lap register all clear on the same edge.
- Prescaler: advances only while the current (registered) state is RUN or LAP. It counts 0..DIV-1, then returns to 0. It holds its value in PAUSE, so the fractional tick is preserved on resume.
- Tick: asserted when the current state is RUN/LAP and the prescaler equals DIV-1. The digits increment on that edge. o_tick is registered and is high in the following cycle (1-cycle latency).
- Tick coinciding with i_start_stop: the increment still happens, and the state goes to PAUSE on the same edge.
- Tick coinciding with i_clear: clear wins; the digits become 0.
- Digit chain, with ripple carry resolved within the same edge:
  - hundredths 0–9, carry into tenths;
  - tenths 0–9, carry into sec_units;
  - sec_units 0–9, carry into sec_tens;
  - sec_tens 0–5.
  - Digits never hold a non-BCD value.
- Rollover: a tick at 59.99 produces 00.00 and a registered o_wrap pulse aligned with o_tick. Counting continues.
- o_disp = lap register in LAP, otherwise the live digits. In PAUSE it shows the frozen live value.
- o_running and o_lap_active are decoded from the registered state.
- Reset mid-count: immediate return to the reset values. No tick or wrap pulse is emitted.

Test Plan:
1. DIV=4; pulse i_start_stop, run 40 cycles -> o_disp=16'h0010, o_running=1, 10 o_tick pulses, each 4 cycles apart.
2. DIV=4; start, 22 cycles, stop; idle 50 cycles; start, 18 cycles -> o_disp=16'h0010 (fraction preserved); o_disp constant during PAUSE.
3. DIV=4; start; lap at 16'h0003; run 20 more cycles -> o_disp stays 16'h0003, o_lap_active=1; lap again -> o_disp=16'h0008 live.
4. DIV=2; start, run to 16'h5999, one more tick -> o_disp=16'h0000 with o_wrap=1 for exactly one cycle, counting continues.
5. i_clear and i_start_stop in the same cycle while in RUN at 16'h0125 -> IDLE, o_disp=0, o_running=0; i_lap in IDLE -> no change.
6. Assert rst asynchronously mid-cycle during LAP -> all outputs 0 before the next i_clk edge; the next i_start_stop restarts from 00.00.
